// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, drives the sram-like instruction handshake,
// and buffers D/M redirects. Define FETCH_PERF_CNT_EN to add the fetch wait-cycle counter.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stallF,
    input  logic [31:0] excepttypeM,
    input  logic [31:0] newpcM,
    input  logic        jrD,
    input  logic [31:0] pc_next_jr,
    input  logic        jumpD,
    input  logic        jalD,
    input  logic [31:0] pc_next_jump,
    input  logic        pcsrcD,
    input  logic [31:0] pc_branchD,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic [31:0] pcF,
    output logic [31:0] instrF,
    output logic        instr_validF,
    output logic        fetch_busy,
    output logic [31:0] fetch_wait_cnt
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t      state, state_nx;
    logic [31:0] pc;
    logic [31:0] pend_pc;
    logic        pend_valid, pend_exc;
    logic        discard, discard_nx;
    logic        valid_q, valid_nx;
    logic [31:0] instr_pc;

    logic        exc_live, d_live;
    logic [31:0] d_target, next_pc;
    logic        advance, accept;

    assign exc_live = (excepttypeM != 32'd0);
    assign d_live   = jrD | jumpD | jalD | pcsrcD;
    assign d_target = jrD             ? pc_next_jr   :
                      (jumpD | jalD)  ? pc_next_jump :
                                        pc_branchD;

    // Pending exceptions outrank live D redirects; pending D redirects only beat pc+4.
    assign next_pc = exc_live   ? newpcM   :
                     pend_exc   ? pend_pc  :
                     d_live     ? d_target :
                     pend_valid ? pend_pc  :
                                  pc + PC_INC;

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nx   = state;
        discard_nx = discard;
        valid_nx   = 1'b0;
        advance    = 1'b0;
        accept     = 1'b0;
        case (state)
            S_REQ: begin
                if (exc_live) discard_nx = 1'b1;
                if (inst_addr_ok) state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (inst_data_ok) begin
                    discard_nx = 1'b0;
                    if (discard || exc_live) begin
                        advance  = 1'b1;
                        state_nx = S_REQ;
                    end else begin
                        accept   = 1'b1;
                        valid_nx = 1'b1;
                        if (stallF) begin
                            state_nx = S_HOLD;
                        end else begin
                            advance  = 1'b1;
                            state_nx = S_REQ;
                        end
                    end
                end else if (exc_live) begin
                    discard_nx = 1'b1;
                end
            end
            S_HOLD: begin
                if (exc_live || !stallF) begin
                    advance  = 1'b1;
                    state_nx = S_REQ;
                end else begin
                    valid_nx = 1'b1;
                end
            end
            default: state_nx = S_REQ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            pend_valid <= 1'b0;
            pend_exc   <= 1'b0;
            discard    <= 1'b0;
            valid_q    <= 1'b0;
            instrF     <= 32'd0;
        end else begin
            state   <= state_nx;
            discard <= discard_nx;
            valid_q <= valid_nx;
            if (advance) pc <= next_pc;
            if (accept) instrF <= inst_rdata;
            if (advance) begin
                pend_valid <= 1'b0;
                pend_exc   <= 1'b0;
            end else if (exc_live) begin
                pend_valid <= 1'b1;
                pend_exc   <= 1'b1;
            end else if (!pend_exc && d_live) begin
                pend_valid <= 1'b1;
            end
        end
    end

    // NOTE: pure datapath registers carry no reset; they are only read once their valid flag is set.
    always_ff @(posedge clk) begin
        if (accept) instr_pc <= pc;
        if (!advance) begin
            if (exc_live) pend_pc <= newpcM;
            else if (!pend_exc && d_live) pend_pc <= d_target;
        end
    end

    assign inst_req     = (state == S_REQ);
    assign inst_addr    = pc;
    assign instr_validF = valid_q;
    // While an instruction is presented, pcF names it; otherwise it names the fetch in flight.
    assign pcF          = valid_q ? instr_pc : pc;
    assign fetch_busy   = (state == S_REQ) ||
                          ((state == S_WAIT) && !(inst_data_ok && !discard));

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (!resetn) wait_cnt <= 32'd0;
        else if (fetch_busy) wait_cnt <= wait_cnt + 32'd1;
    end

    assign fetch_wait_cnt = wait_cnt;
`else
    assign fetch_wait_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed, table-driven bench for pc_fetch_ctrl: per-cycle stimulus/expected rows,
// plus a hand-written slow-memory sequence for the wait-cycle counter.
module tb_pc_fetch_ctrl;

    logic        clk;
    logic        resetn;
    logic        stallF;
    logic [31:0] excepttypeM, newpcM;
    logic        jrD, jumpD, jalD, pcsrcD;
    logic [31:0] pc_next_jr, pc_next_jump, pc_branchD;
    logic        inst_req, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr, inst_rdata;
    logic [31:0] pcF, instrF, fetch_wait_cnt;
    logic        instr_validF, fetch_busy;

    pc_fetch_ctrl dut (
        .clk           (clk),
        .resetn        (resetn),
        .stallF        (stallF),
        .excepttypeM   (excepttypeM),
        .newpcM        (newpcM),
        .jrD           (jrD),
        .pc_next_jr    (pc_next_jr),
        .jumpD         (jumpD),
        .jalD          (jalD),
        .pc_next_jump  (pc_next_jump),
        .pcsrcD        (pcsrcD),
        .pc_branchD    (pc_branchD),
        .inst_req      (inst_req),
        .inst_addr     (inst_addr),
        .inst_addr_ok  (inst_addr_ok),
        .inst_data_ok  (inst_data_ok),
        .inst_rdata    (inst_rdata),
        .pcF           (pcF),
        .instrF        (instrF),
        .instr_validF  (instr_validF),
        .fetch_busy    (fetch_busy),
        .fetch_wait_cnt(fetch_wait_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] Z    = 32'h0000_0000;
    localparam logic [31:0] A0   = 32'hBFC0_0000;
    localparam logic [31:0] A4   = 32'hBFC0_0004;
    localparam logic [31:0] A8   = 32'hBFC0_0008;
    localparam logic [31:0] AC   = 32'hBFC0_000C;
    localparam logic [31:0] T100 = 32'hBFC0_0100;
    localparam logic [31:0] T380 = 32'hBFC0_0380;
    localparam logic [31:0] T500 = 32'hBFC0_0500;
    localparam logic [31:0] JRT  = 32'h8000_0000;
    localparam logic [31:0] JMT  = 32'h9000_0000;
    localparam logic [31:0] TOP  = 32'hFFFF_FFFC;
    localparam logic [31:0] D0   = 32'h2408_0001;
    localparam logic [31:0] D1   = 32'h2409_0002;
    localparam logic [31:0] D2   = 32'h240A_0003;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    // Redirect mask bits: {exception, jr, jump, jal, branch}
    localparam logic [4:0] NO = 5'b00000;
    localparam logic [4:0] EX = 5'b10000;
    localparam logic [4:0] JR = 5'b01000;
    localparam logic [4:0] JM = 5'b00100;
    localparam logic [4:0] JL = 5'b00010;
    localparam logic [4:0] BR = 5'b00001;

    typedef struct {
        logic        rst, aok, dok, stall;
        logic [31:0] rdata;
        logic [4:0]  redir;
        logic [31:0] etgt, jtgt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_v;
        logic [31:0] e_pcf, e_ins;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    int   busy_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input int rst, input int aok, input int dok, input int stall,
                                input logic [31:0] rdata, input logic [4:0] redir,
                                input logic [31:0] etgt, input logic [31:0] jtgt,
                                input int e_req, input logic [31:0] e_addr, input int e_v,
                                input logic [31:0] e_pcf, input logic [31:0] e_ins,
                                input int e_busy);
        vec_t v;
        v.rst = (rst != 0);  v.aok = (aok != 0);  v.dok = (dok != 0);  v.stall = (stall != 0);
        v.rdata = rdata;  v.redir = redir;  v.etgt = etgt;  v.jtgt = jtgt;
        v.e_req = (e_req != 0);  v.e_addr = e_addr;  v.e_v = (e_v != 0);
        v.e_pcf = e_pcf;  v.e_ins = e_ins;  v.e_busy = (e_busy != 0);
        vecs.push_back(v);
    endfunction

    function automatic void rst_row();
        add(1, 0, 0, 0, Z, NO, Z, Z, 0, Z, 0, Z, Z, 0);
    endfunction

    task automatic do_fetch(input logic [31:0] a);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            resetn       = 1'b1;
            inst_addr_ok = (k == 2);
            inst_data_ok = 1'b0;
            #1;
            check("perf req", {31'd0, inst_req}, 32'd1);
            check("perf addr", inst_addr, a);
            check("perf busy", {31'd0, fetch_busy}, 32'd1);
            busy_cycles++;
        end
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            inst_addr_ok = 1'b0;
            inst_data_ok = (j == 3);
            inst_rdata   = a ^ 32'h5555_0000;
            #1;
            check("perf busy", {31'd0, fetch_busy}, (j == 3) ? 32'd0 : 32'd1);
            if (j < 3) busy_cycles++;
        end
    endtask

    initial begin
        logic [31:0] exp_cnt;
        resetn = 1'b0;  stallF = 1'b0;  excepttypeM = Z;  newpcM = Z;
        jrD = 1'b0;  jumpD = 1'b0;  jalD = 1'b0;  pcsrcD = 1'b0;
        pc_next_jr = Z;  pc_next_jump = Z;  pc_branchD = Z;
        inst_addr_ok = 1'b0;  inst_data_ok = 1'b0;  inst_rdata = Z;

        // Sequential fetch with one-cycle addr_ok and data_ok delays
        rst_row();
        add(0, 0, 0, 0, Z,  NO, Z, Z, 1, A0, 0, A0, Z,  1);
        add(0, 1, 0, 0, Z,  NO, Z, Z, 1, A0, 0, A0, Z,  1);
        add(0, 0, 0, 0, Z,  NO, Z, Z, 0, Z,  0, A0, Z,  1);
        add(0, 0, 1, 0, D0, NO, Z, Z, 0, Z,  0, A0, Z,  0);
        add(0, 0, 0, 0, Z,  NO, Z, Z, 1, A4, 1, A0, D0, 1);
        add(0, 1, 0, 0, Z,  NO, Z, Z, 1, A4, 0, A4, Z,  1);
        add(0, 0, 0, 0, Z,  NO, Z, Z, 0, Z,  0, A4, Z,  1);
        add(0, 0, 1, 0, D1, NO, Z, Z, 0, Z,  0, A4, Z,  0);
        add(0, 0, 0, 0, Z,  NO, Z, Z, 1, A8, 1, A4, D1, 1);
        add(0, 1, 0, 0, Z,  NO, Z, Z, 1, A8, 0, A8, Z,  1);
        add(0, 0, 0, 0, Z,  NO, Z, Z, 0, Z,  0, A8, Z,  1);
        add(0, 0, 1, 0, D2, NO, Z, Z, 0, Z,  0, A8, Z,  0);
        add(0, 0, 0, 0, Z,  NO, Z, Z, 1, AC, 1, A8, D2, 1);
        // Stall on delivery of BFC00004 -> held for 3 cycles
        rst_row();
        add(0, 1, 0, 0, Z,    NO, Z, Z, 1, A0, 0, A0, Z,  1);
        add(0, 0, 1, 0, D0,   NO, Z, Z, 0, Z,  0, A0, Z,  0);
        add(0, 1, 0, 0, Z,    NO, Z, Z, 1, A4, 1, A0, D0, 1);
        add(0, 0, 1, 1, D1,   NO, Z, Z, 0, Z,  0, A4, Z,  0);
        add(0, 0, 0, 1, JUNK, NO, Z, Z, 0, Z,  1, A4, D1, 0);
        add(0, 0, 0, 1, JUNK, NO, Z, Z, 0, Z,  1, A4, D1, 0);
        add(0, 0, 0, 1, JUNK, NO, Z, Z, 0, Z,  1, A4, D1, 0);
        add(0, 0, 0, 0, JUNK, NO, Z, Z, 0, Z,  1, A4, D1, 0);
        add(0, 0, 0, 0, Z,    NO, Z, Z, 1, A8, 0, A8, Z,  1);
        // Branch while the delay slot is in flight
        rst_row();
        add(0, 1, 0, 0, Z,  NO, Z, Z, 1, A0,   0, A0,   Z,  1);
        add(0, 0, 1, 0, D0, NO, Z, Z, 0, Z,    0, A0,   Z,  0);
        add(0, 1, 0, 0, Z,  NO, Z, Z, 1, A4,   1, A0,   D0, 1);
        add(0, 0, 0, 0, Z,  BR, Z, Z, 0, Z,    0, A4,   Z,  1);
        add(0, 0, 1, 0, D1, NO, Z, Z, 0, Z,    0, A4,   Z,  0);
        add(0, 0, 0, 0, Z,  NO, Z, Z, 1, T100, 1, A4,   D1, 1);
        add(0, 0, 0, 0, Z,  NO, Z, Z, 1, T100, 0, T100, Z,  1);
        // Exception during S_WAIT of BFC00008
        rst_row();
        add(0, 1, 0, 0, Z,  NO, Z,    Z, 1, A0,   0, A0,   Z,  1);
        add(0, 0, 1, 0, D0, NO, Z,    Z, 0, Z,    0, A0,   Z,  0);
        add(0, 1, 0, 0, Z,  NO, Z,    Z, 1, A4,   1, A0,   D0, 1);
        add(0, 0, 1, 0, D1, NO, Z,    Z, 0, Z,    0, A4,   Z,  0);
        add(0, 1, 0, 0, Z,  NO, Z,    Z, 1, A8,   1, A4,   D1, 1);
        add(0, 0, 0, 0, Z,  EX, T380, Z, 0, Z,    0, A8,   Z,  1);
        add(0, 0, 1, 0, D2, NO, Z,    Z, 0, Z,    0, A8,   Z,  1);
        add(0, 0, 0, 0, Z,  NO, Z,    Z, 1, T380, 0, T380, Z,  1);
        add(0, 0, 0, 0, Z,  NO, Z,    Z, 1, T380, 0, T380, Z,  1);
        // Exception and jr together, then jr alone before the advance
        rst_row();
        add(0, 1, 0, 0, Z,  NO,      Z,    Z, 1, A0,   0, A0,   Z, 1);
        add(0, 0, 0, 0, Z,  EX | JR, T380, Z, 0, Z,    0, A0,   Z, 1);
        add(0, 0, 0, 0, Z,  JR,      Z,    Z, 0, Z,    0, A0,   Z, 1);
        add(0, 0, 1, 0, D0, JR,      Z,    Z, 0, Z,    0, A0,   Z, 1);
        add(0, 0, 0, 0, Z,  NO,      Z,    Z, 1, T380, 0, T380, Z, 1);
        // Exception in S_HOLD overrides the stall
        rst_row();
        add(0, 1, 0, 0, Z,  NO, Z,    Z, 1, A0,   0, A0,   Z,  1);
        add(0, 0, 1, 1, D0, NO, Z,    Z, 0, Z,    0, A0,   Z,  0);
        add(0, 0, 0, 1, Z,  NO, Z,    Z, 0, Z,    1, A0,   D0, 0);
        add(0, 0, 0, 1, Z,  EX, T380, Z, 0, Z,    1, A0,   D0, 0);
        add(0, 0, 0, 1, Z,  NO, Z,    Z, 1, T380, 0, T380, Z,  1);
        // D-redirect priority (live and buffered) and PC wrap at 2^32
        rst_row();
        add(0, 1, 0, 0, Z,  NO,           Z, Z,   1, A0,  0, A0,  Z,  1);
        add(0, 0, 1, 0, D0, JR | JM | BR, Z, JMT, 0, Z,   0, A0,  Z,  0);
        add(0, 1, 0, 0, Z,  NO,           Z, Z,   1, JRT, 1, A0,  D0, 1);
        add(0, 0, 0, 0, Z,  JL | BR,      Z, TOP, 0, Z,   0, JRT, Z,  1);
        add(0, 0, 1, 0, D1, NO,           Z, Z,   0, Z,   0, JRT, Z,  0);
        add(0, 1, 0, 0, Z,  NO,           Z, Z,   1, TOP, 1, JRT, D1, 1);
        add(0, 0, 1, 0, D2, NO,           Z, Z,   0, Z,   0, TOP, Z,  0);
        add(0, 0, 0, 0, Z,  NO,           Z, Z,   1, Z,   1, TOP, D2, 1);
        // Exception with addr_ok same cycle, then exception with data_ok same cycle
        rst_row();
        add(0, 1, 0, 0, Z,  EX, T380, Z, 1, A0,   0, A0,   Z, 1);
        add(0, 0, 1, 0, D0, NO, Z,    Z, 0, Z,    0, A0,   Z, 1);
        add(0, 1, 0, 0, Z,  NO, Z,    Z, 1, T380, 0, T380, Z, 1);
        add(0, 0, 1, 0, D1, EX, T500, Z, 0, Z,    0, T380, Z, 0);
        add(0, 0, 0, 0, Z,  NO, Z,    Z, 1, T500, 0, T500, Z, 1);
        // Exception while the request is still waiting for addr_ok
        rst_row();
        add(0, 0, 0, 0, Z,  EX, T380, Z, 1, A0,   0, A0,   Z, 1);
        add(0, 1, 0, 0, Z,  NO, Z,    Z, 1, A0,   0, A0,   Z, 1);
        add(0, 0, 1, 0, D0, NO, Z,    Z, 0, Z,    0, A0,   Z, 1);
        add(0, 0, 0, 0, Z,  NO, Z,    Z, 1, T380, 0, T380, Z, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            resetn       = !vecs[i].rst;
            inst_addr_ok = vecs[i].aok;
            inst_data_ok = vecs[i].dok;
            stallF       = vecs[i].stall;
            inst_rdata   = vecs[i].rdata;
            excepttypeM  = vecs[i].redir[4] ? 32'h0000_0001 : 32'h0;
            newpcM       = vecs[i].etgt;
            jrD          = vecs[i].redir[3];
            pc_next_jr   = JRT;
            jumpD        = vecs[i].redir[2];
            jalD         = vecs[i].redir[1];
            pc_next_jump = vecs[i].jtgt;
            pcsrcD       = vecs[i].redir[0];
            pc_branchD   = T100;
            #1;
            if (!vecs[i].rst) begin
                check($sformatf("v%0d inst_req", i), {31'd0, inst_req}, {31'd0, vecs[i].e_req});
                if (vecs[i].e_req)
                    check($sformatf("v%0d inst_addr", i), inst_addr, vecs[i].e_addr);
                check($sformatf("v%0d instr_validF", i), {31'd0, instr_validF}, {31'd0, vecs[i].e_v});
                check($sformatf("v%0d pcF", i), pcF, vecs[i].e_pcf);
                if (vecs[i].e_v)
                    check($sformatf("v%0d instrF", i), instrF, vecs[i].e_ins);
                check($sformatf("v%0d fetch_busy", i), {31'd0, fetch_busy}, {31'd0, vecs[i].e_busy});
            end
        end

        // Slow memory: addr_ok after 2 cycles, data_ok after 3 cycles, for three fetches
        @(negedge clk);
        resetn = 1'b0;  stallF = 1'b0;  excepttypeM = Z;
        jrD = 1'b0;  jumpD = 1'b0;  jalD = 1'b0;  pcsrcD = 1'b0;
        inst_addr_ok = 1'b0;  inst_data_ok = 1'b0;
        @(negedge clk);
        #1;
        check("perf cnt after reset", fetch_wait_cnt, 32'd0);
        do_fetch(A0);
        do_fetch(A4);
        do_fetch(A8);
        @(negedge clk);
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        #1;
`ifdef FETCH_PERF_CNT_EN
        exp_cnt = busy_cycles;
`else
        exp_cnt = 32'd0;
`endif
        check("perf cnt", fetch_wait_cnt, exp_cnt);
        check("perf last valid", {31'd0, instr_validF}, 32'd1);
        check("perf last instr", instrF, A8 ^ 32'h5555_0000);
        check("perf next addr", inst_addr, AC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
